// File: rtl/spi_lcd_pkg.sv
// Shared types and constants for the SPI LCD transmitter.
// FSM state encoding and the meaning of the LCD D/C line.
package spi_lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_LO,
        SHIFT_HI,
        GAP
    } state_e;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

endpackage

// File: rtl/spi_lcd_fifo.sv
// Synchronous show-ahead FIFO holding {dc, word} entries for the transmitter.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module spi_lcd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    // Read and write pointers advance on accepted push/pop only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_lcd_tx.sv
// SPI mode-0 transmitter for LCD controllers with a command/data FIFO.
// Consecutive words with the same D/C value share one cs_n frame.
// Optional MISO capture is enabled by defining SPI_LCD_TX_MISO_EN.
module spi_lcd_tx
    import spi_lcd_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 4,
    parameter int CS_GAP     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_dc,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              lcd_dc,
    output logic              busy,
    output logic              word_done
`ifdef SPI_LCD_TX_MISO_EN
    ,
    input  logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid
`endif
);

    localparam int              BW         = $clog2(DATA_W + 1);
    localparam logic [7:0]      DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [3:0]      GAP_RELOAD = 4'(CS_GAP - 1);
    localparam logic [BW-1:0]   BIT_FULL   = BW'(DATA_W);
    localparam logic [BW-1:0]   BIT_ONE    = BW'(1);

    state_e              state_q, state_d;
    logic [7:0]          div_q, div_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [3:0]          gap_q, gap_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic                dc_q, dc_d;
    logic                wd_q, wd_d;
    logic                load;

    logic [DATA_W:0]     fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic [DATA_W-1:0]   fifo_word;
    logic                fifo_dc;

    assign fifo_word = fifo_rdata[DATA_W-1:0];
    assign fifo_dc   = fifo_rdata[DATA_W];

    spi_lcd_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid),
        .wdata_i ({in_dc, in_data}),
        .pop_i   (load),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready  = !fifo_full;
    assign busy      = (state_q != IDLE) || !fifo_empty;
    assign sclk      = sclk_q;
    assign mosi      = sh_q[DATA_W-1];
    assign cs_n      = cs_n_q;
    assign lcd_dc    = dc_q;
    assign word_done = wd_q;

    // Next-state logic; all bus outputs are computed here and registered so
    // they change exactly on the state transition edge.
    always_comb begin
        state_d = state_q;
        div_d   = (div_q != 8'd0) ? div_q - 8'd1 : div_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        sh_d    = sh_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        dc_d    = dc_q;
        wd_d    = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    load    = 1'b1;
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                end
            end
            SETUP, SHIFT_LO: begin
                if (div_q == 8'd0) begin
                    state_d = SHIFT_HI;
                    div_d   = DIV_RELOAD;
                    sclk_d  = 1'b1;
                end
            end
            SHIFT_HI: begin
                if (div_q == 8'd0) begin
                    sclk_d = 1'b0;
                    div_d  = DIV_RELOAD;
                    if (bit_q == BIT_ONE) begin
                        wd_d = 1'b1;
                        if (!fifo_empty && (fifo_dc == dc_q)) begin
                            load    = 1'b1;
                            state_d = SHIFT_LO;
                        end else begin
                            state_d = GAP;
                            cs_n_d  = 1'b1;
                            sh_d    = '0;
                            gap_d   = GAP_RELOAD;
                        end
                    end else begin
                        bit_d   = bit_q - BIT_ONE;
                        sh_d    = {sh_q[DATA_W-2:0], 1'b0};
                        state_d = SHIFT_LO;
                    end
                end
            end
            GAP: begin
                // When work is already waiting at the end of the gap the
                // pass through IDLE is folded into this edge, keeping the
                // cs_n-high time at exactly CS_GAP half-periods.
                if (div_q == 8'd0) begin
                    if (gap_q != 4'd0) begin
                        gap_d = gap_q - 4'd1;
                        div_d = DIV_RELOAD;
                    end else if (!fifo_empty) begin
                        load    = 1'b1;
                        state_d = SETUP;
                        cs_n_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            sh_d  = fifo_word;
            dc_d  = fifo_dc;
            bit_d = BIT_FULL;
            div_d = DIV_RELOAD;
        end
    end

    // State and output registers; reset drops any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            sh_q    <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            dc_q    <= DC_CMD;
            wd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            sh_q    <= sh_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            dc_q    <= dc_d;
            wd_q    <= wd_d;
        end
    end

`ifdef SPI_LCD_TX_MISO_EN
    logic [DATA_W-1:0] rx_sh_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

    // Sample miso on the edge that raises sclk; publish with word_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= wd_d;
            if (sclk_d && !sclk_q) begin
                rx_sh_q <= {rx_sh_q[DATA_W-2:0], miso};
            end
            if (wd_d) begin
                rx_data_q <= rx_sh_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_lcd_tx.sv
// Directed self-checking bench for spi_lcd_tx with default parameters
// (DATA_W=8, FIFO_DEPTH=8, CLK_DIV=4, CS_GAP=2).
// The MISO section is only built when SPI_LCD_TX_MISO_EN is defined.
module tb_spi_lcd_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_dc = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready, sclk, mosi, cs_n, lcd_dc, busy, word_done;
`ifdef SPI_LCD_TX_MISO_EN
   logic       miso = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] misoPat = 8'hC3;
   int         rxCoincErr = 0;
   int         lastRx = 0;
`endif

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;

   // Monitor state
   logic       prevSclk = 1'b0, prevCs = 1'b1, prevMosi = 1'b0, prevBusy = 1'b0;
   logic [7:0] rxWord = 8'h00;
   int         bitCnt = 0;
   int         csFallCyc = 0, csRiseCyc = 0, csRiseCount = 0;
   int         lastGap = -1, lastLat = -1, lastBits = -1;
   int         busyFallCyc = 0, wdCount = 0, viol = 0;
   logic       csHighSeen = 1'b0;
   int         gotQ[$];
   int         expQ[$];
   int         wdCycQ[$];

   spi_lcd_tx dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_dc     (in_dc),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .sclk      (sclk),
      .mosi      (mosi),
      .cs_n      (cs_n),
      .lcd_dc    (lcd_dc),
      .busy      (busy),
      .word_done (word_done)
`ifdef SPI_LCD_TX_MISO_EN
      ,
      .miso      (miso),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid)
`endif
   );

   // 10 ns system clock
   always #5 clk = ~clk;

   // Cycle counter used to timestamp bus events
   always @(posedge clk) cyc <= cyc + 1;

   // Bus monitor sampled on the falling clk edge: rebuilds each word from
   // mosi at sclk rises and timestamps cs_n, word_done and busy edges.
   always @(negedge clk) begin
      if (!rst_n) begin
         rxWord = 8'h00;
         bitCnt = 0;
         prevSclk = 1'b0;
         prevCs = 1'b1;
         prevMosi = 1'b0;
         prevBusy = 1'b0;
      end else begin
         if (!cs_n && prevCs) begin
            csFallCyc = cyc;
            if (csHighSeen) lastGap = cyc - csRiseCyc;
         end
         if (cs_n && !prevCs) begin
            csRiseCyc = cyc;
            csHighSeen = 1'b1;
            csRiseCount++;
         end
         if (sclk && !prevSclk) begin
            rxWord = {rxWord[6:0], mosi};
            bitCnt++;
            if (cs_n) viol++;
         end
         if (sclk && prevSclk && (mosi != prevMosi)) viol++;
         if (word_done) begin
            gotQ.push_back({23'd0, lcd_dc, rxWord});
            wdCycQ.push_back(cyc);
            lastLat = cyc - csFallCyc;
            lastBits = bitCnt;
            bitCnt = 0;
            wdCount++;
         end
         if (!busy && prevBusy) busyFallCyc = cyc;
`ifdef SPI_LCD_TX_MISO_EN
         if (rx_valid != word_done) rxCoincErr++;
         if (rx_valid) lastRx = int'(rx_data);
         if (bitCnt < 8) miso = misoPat[7 - bitCnt];
`endif
         prevSclk = sclk;
         prevCs = cs_n;
         prevMosi = mosi;
         prevBusy = busy;
      end
   end

   // Single comparison point: counts and reports every check
   task automatic checkOutput(input string tag, input int actual, input int expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  tag, actual, actual, expected, expected);
      end
   endtask

   // Push one word; called right after a falling edge, waits for in_ready
   task automatic applyStimulus(input logic dc, input logic [7:0] d);
      int guard = 0;
      while (!in_ready && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      in_valid = 1'b1;
      in_dc = dc;
      in_data = d;
      expQ.push_back({23'd0, dc, d});
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Wait (bounded) until the transmitter has drained everything
   task automatic waitIdle(input string tag);
      int n = 0;
      @(negedge clk);
      while (busy && n < 4000) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      checkOutput({tag, "_idle"}, int'(busy), 0);
   endtask

   // Compare received words (dc and data) against the pushed sequence
   task automatic checkWords(input string tag);
      while (expQ.size() > 0) begin
         if (gotQ.size() == 0) begin
            checkOutput({tag, "_missing"}, 0, expQ.size());
            expQ.delete();
         end else begin
            checkOutput(tag, gotQ.pop_front(), expQ.pop_front());
         end
      end
      checkOutput({tag, "_extra"}, gotQ.size(), 0);
      gotQ.delete();
   endtask

   initial begin
      int rises0;
      int wd0;
      int guard;

      // Reset values
      repeat (3) @(negedge clk);
      checkOutput("rst_cs_n", int'(cs_n), 1);
      checkOutput("rst_sclk", int'(sclk), 0);
      checkOutput("rst_mosi", int'(mosi), 0);
      checkOutput("rst_lcd_dc", int'(lcd_dc), 0);
      checkOutput("rst_word_done", int'(word_done), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_in_ready", int'(in_ready), 1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single command 0x2A: 64 cycles from cs_n fall to word_done
      applyStimulus(1'b0, 8'h2A);
      waitIdle("t1");
      checkOutput("t1_latency", lastLat, 64);
      checkOutput("t1_bits", lastBits, 8);
      checkWords("t1_word");

      // Three data words chained in one frame, then an 8-cycle gap
      rises0 = csRiseCount;
      wdCycQ.delete();
      applyStimulus(1'b1, 8'h12);
      applyStimulus(1'b1, 8'h34);
      applyStimulus(1'b1, 8'h56);
      waitIdle("t2");
      checkOutput("t2_cs_rises", csRiseCount - rises0, 1);
      checkOutput("t2_wd_count", wdCycQ.size(), 3);
      if (wdCycQ.size() == 3) begin
         checkOutput("t2_space1", wdCycQ[1] - wdCycQ[0], 64);
         checkOutput("t2_space2", wdCycQ[2] - wdCycQ[1], 64);
         checkOutput("t2_tail", busyFallCyc - wdCycQ[2], 8);
      end
      checkWords("t2_word");

      // Command then data: dc change forces a CS_GAP*CLK_DIV = 8 cycle gap
      applyStimulus(1'b0, 8'h2C);
      applyStimulus(1'b1, 8'hFF);
      waitIdle("t3");
      checkOutput("t3_gap", lastGap, 8);
      checkOutput("t3_latency", lastLat, 64);
      checkOutput("t3_lcd_dc", int'(lcd_dc), 1);
      checkWords("t3_word");

      // Nine words: one in flight plus eight queued fills the FIFO
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8'h80 + 8'(i));
      checkOutput("t4_in_ready_full", int'(in_ready), 0);
      // Pushes against a full FIFO must be ignored
      in_valid = 1'b1;
      in_dc = 1'b1;
      in_data = 8'h77;
      repeat (5) @(negedge clk);
      checkOutput("t4_still_full", int'(in_ready), 0);
      in_valid = 1'b0;
      waitIdle("t4");
      checkOutput("t4_in_ready_after", int'(in_ready), 1);
      checkWords("t4_word");

      // Reset in the middle of word 0xA5
      wd0 = wdCount;
      applyStimulus(1'b1, 8'hA5);
      expQ.delete();
      guard = 0;
      while (cs_n && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("t5_cs_low", int'(cs_n), 0);
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t5_cs_n", int'(cs_n), 1);
      checkOutput("t5_sclk", int'(sclk), 0);
      checkOutput("t5_busy", int'(busy), 0);
      checkOutput("t5_in_ready", int'(in_ready), 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      checkOutput("t5_no_word_done", wdCount - wd0, 0);
      checkOutput("t5_idle_busy", int'(busy), 0);
      checkOutput("t5_idle_cs_n", int'(cs_n), 1);
      gotQ.delete();

`ifdef SPI_LCD_TX_MISO_EN
      // MISO capture: slave returns 0xC3 during a command word
      applyStimulus(1'b0, 8'h3C);
      waitIdle("t6");
      checkOutput("t6_rx_data", lastRx, 8'hC3);
      checkOutput("t6_rx_coincident", rxCoincErr, 0);
      checkWords("t6_word");
`endif

      checkOutput("mode0_violations", viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Hard time limit so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: got running, expected finished");
      $fatal(1, "[TB] time limit reached");
   end

endmodule

// File: doc/spi_lcd_tx.md
SPI_LCD_TX -- requirements
Module: spi_lcd_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bits per SPI word (legal 4..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, command/data FIFO entries (power of two, 2..64).
REQ-003 SHALL have parameter CLK_DIV, default 4, clk cycles per SCLK half-period (legal 1..255).
REQ-004 SHALL have parameter CS_GAP, default 2, SCLK half-periods with cs_n high between frames (legal 1..15).
REQ-005 SHALL have port clk  in  1  system clock.
REQ-006 SHALL have port rst_n  in  1  reset; one clock, asynchronous assert, active-low.
REQ-007 SHALL have port in_valid  in  1  push request.
REQ-008 SHALL have port in_dc  in  1  0 = command, 1 = pixel/data word.
REQ-009 SHALL have port in_data  in  DATA_W  word to send, MSB first.
REQ-010 SHALL have port in_ready  out  1  FIFO not full.
REQ-011 SHALL have ports sclk, mosi, cs_n, lcd_dc  out  1 each  LCD serial bus.
REQ-012 SHALL have port busy  out  1  FSM not IDLE or FIFO not empty.
REQ-013 SHALL have port word_done  out  1  one-cycle pulse per completed word.

Function
REQ-014 SHALL accept a word when in_valid and in_ready are both high on a rising clk edge; in_valid with in_ready low SHALL drop nothing and change no state.
REQ-015 SHALL use SPI mode 0: sclk idles low, mosi changes only while sclk low, LCD samples on sclk rise.
REQ-016 SHALL use FSM states IDLE, SETUP, SHIFT_LO, SHIFT_HI, GAP.
REQ-017 IDLE -> SETUP when FIFO non-empty: pop entry, cs_n=0, lcd_dc=entry dc, mosi=MSB, on the same edge.
REQ-018 SETUP SHALL last CLK_DIV cycles, then -> SHIFT_HI.
REQ-019 SHIFT_HI: sclk=1 for CLK_DIV cycles; then last bit -> word_done pulse; else -> SHIFT_LO with mosi=next bit.
REQ-020 SHIFT_LO: sclk=0 for CLK_DIV cycles, then -> SHIFT_HI.
REQ-021 After last bit, if FIFO non-empty and next dc equals current lcd_dc, SHALL pop and continue (SHIFT_LO, cs_n held low, no gap); otherwise -> GAP.
REQ-022 GAP: cs_n=1, sclk=0 for CS_GAP*CLK_DIV cycles, then -> IDLE (lcd_dc holds its value).
REQ-023 One frame SHALL take exactly (2*DATA_W)*CLK_DIV cycles from cs_n fall to the word_done pulse.
REQ-024 Bit counter SHALL be $clog2(DATA_W+1) bits wide; divider counter 8 bits, reload CLK_DIV-1, no wrap past zero.
REQ-025 Simultaneous push and pop on a full FIFO SHALL be allowed only when in_ready was high; on an empty FIFO the pushed word is popped no earlier than the next cycle.

Reset
REQ-026 On rst_n low SHALL immediately force: cs_n=1, sclk=0, mosi=0, lcd_dc=0, word_done=0, busy=0, in_ready=1, FSM=IDLE, FIFO empty.
REQ-027 Reset mid-frame SHALL abort the frame with no word_done; released state SHALL be idle.

Configuration
REQ-028 Macro SPI_LCD_TX_MISO_EN SHALL, when defined, add port miso (in, 1) and ports rx_data (out, DATA_W) and rx_valid (out, 1); miso sampled on each sclk rise, rx_valid pulsed with word_done; rx_data resets to 0.
REQ-029 Without SPI_LCD_TX_MISO_EN those ports and capture logic SHALL not exist.

Structure
REQ-030 Package spi_lcd_pkg SHALL hold the FSM state enum and DC_CMD/DC_DATA constants.
REQ-031 The FIFO SHALL be sub-module spi_lcd_fifo (synchronous, width DATA_W+1, depth FIFO_DEPTH, full/empty flags).

Verification
REQ-032 Push cmd 0x2A (DATA_W=8, CLK_DIV=4) -> lcd_dc=0, mosi 0,0,1,0,1,0,1,0 on sclk rises, word_done 64 cycles after cs_n falls.
REQ-033 Push data 0x12,0x34,0x56 back-to-back -> cs_n low for 3 words continuously, then high for 8 cycles.
REQ-034 Push cmd 0x2C then data 0xFF -> cs_n high gap of CS_GAP*CLK_DIV cycles between words, lcd_dc 0 then 1.
REQ-035 Push 9 words with FIFO_DEPTH=8 while stalled -> in_ready=0 after 8 accepted (1 in flight), no word lost or duplicated.
REQ-036 rst_n low in mid-word 0xA5 -> cs_n=1, sclk=0 same cycle, no word_done, busy=0.
REQ-037 With SPI_LCD_TX_MISO_EN, miso drives 0xC3 -> rx_data=0xC3, rx_valid coincident with word_done.
